// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings and widths for the ALU operand-fetch/writeback stage.
package alu_issue_stage_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDI = 2'b01,
    OP_MOV  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
  } instr_t;

endpackage

// File: rtl/alu_issue_stage_regfile_4x8.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module regfile_4x8
  import alu_issue_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0]    rdata_b
);

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (we) begin
      rf_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign rdata_a = rf_q[raddr_a];
  assign rdata_b = rf_q[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch and writeback around an external 8-bit ALU; one instruction
// per three cycles (IDLE accept, READ operands, EXEC write-back).
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_instr,
  output logic                 in_ready,
  input  logic                 ext_we,
  input  logic [REG_IDX_W-1:0] ext_addr,
  input  logic [DATA_W-1:0]    ext_data,
  output logic [DATA_W-1:0]    alu_A,
  output logic [DATA_W-1:0]    alu_B,
  output logic                 alu_op,
  input  logic [DATA_W-1:0]    alu_S,
  output logic [DATA_W-1:0]    result,
  output logic [REG_IDX_W-1:0] result_rd,
  output logic                 result_valid
);

  state_e               state_q, state_d;
  instr_t               instr_q, instr_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]    alu_b_q, alu_b_d;
  logic                 alu_op_q, alu_op_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [REG_IDX_W-1:0] result_rd_q, result_rd_d;
  logic                 result_valid_q, result_valid_d;

  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    rd_a, rd_b;

  regfile_4x8 u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr_q.rs),
    .rdata_a (rd_a),
    .raddr_b (instr_q.rt),
    .rdata_b (rd_b)
  );

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    result_d       = result_q;
    result_rd_d    = result_rd_q;
    result_valid_d = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = ext_addr;
    rf_wdata       = ext_data;

    unique case (state_q)
      S_IDLE: begin
        // External write shares the accept edge, so READ sees the new value.
        rf_we = ext_we;
        if (in_valid) begin
          instr_d = instr_t'(in_instr);
          state_d = S_READ;
        end
      end
      S_READ: begin
        alu_a_d  = rd_a;
        alu_op_d = 1'b0;
        unique case (instr_q.op)
          OP_ADD:  alu_b_d = rd_b;
          OP_ADDI: alu_b_d = {{(DATA_W-REG_IDX_W){1'b0}}, instr_q.rt};
          OP_MOV:  alu_b_d = '0;
          OP_SUB: begin
            alu_b_d  = rd_b;
            alu_op_d = 1'b1;
          end
        endcase
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rf_we          = 1'b1;
        rf_waddr       = instr_q.rd;
        rf_wdata       = alu_S;
        result_d       = alu_S;
        result_rd_d    = instr_q.rd;
        result_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      instr_q        <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= 1'b0;
      result_q       <= '0;
      result_rd_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      result_q       <= result_d;
      result_rd_q    <= result_rd_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE) && !reset;
  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_rd    = result_rd_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU and a scoreboard of write-backs.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       in_ready;
  logic       ext_we;
  logic [1:0] ext_addr;
  logic [7:0] ext_data;
  logic [7:0] alu_A, alu_B, alu_S, result;
  logic       alu_op;
  logic [1:0] result_rd;
  logic       result_valid;

  alu_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .ext_we       (ext_we),
    .ext_addr     (ext_addr),
    .ext_data     (ext_data),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_op       (alu_op),
    .alu_S        (alu_S),
    .result       (result),
    .result_rd    (result_rd),
    .result_valid (result_valid)
  );

  // The downstream ALU: add, or subtract when op is set.
  assign alu_S = alu_op ? (alu_A - alu_B) : (alu_A + alu_B);

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int res; int rd; } exp_t;
  exp_t sb[$];
  int   rf[4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] mk(input int op, input int rd, input int rs, input int rt);
    logic [7:0] w;
    w = {op[1:0], rd[1:0], rs[1:0], rt[1:0]};
    return w;
  endfunction

  // Monitor: every write-back pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result_valid actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("result", {8'h0, result}, e.res[15:0]);
        chk("result_rd", {14'h0, result_rd}, e.rd[15:0]);
      end
    end
  end

  task automatic wait_ready();
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic ext_wr(input int a, input int d);
    wait_ready();
    ext_we = 1'b1; ext_addr = a[1:0]; ext_data = d[7:0];
    @(negedge clk);
    ext_we = 1'b0;
    rf[a] = d;
  endtask

  // Called at a negedge; returns at the negedge inside EXEC.
  task automatic issue(input logic [7:0] instr, input bit hold, input bit chk_space,
                       input bit ext_acc, input int ea, input int ed,
                       input bit ext_read, input int ra, input int rdat);
    int op, a, b, res;
    in_valid = 1'b1; in_instr = instr;
    ext_we = ext_acc; ext_addr = ea[1:0]; ext_data = ed[7:0];
    wait_ready();
    if (in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout actual=0 required=1 (t=%0t)", $time);
      in_valid = 1'b0; ext_we = 1'b0;
      return;
    end
    if (chk_space) chk("accept_spacing", 16'(cyc - last_acc), 16'd3);
    last_acc = cyc;
    if (ext_acc) rf[ea] = ed;
    op = int'(instr[7:6]);
    a  = rf[instr[3:2]];
    case (op)
      0, 3:    b = rf[instr[1:0]];
      1:       b = int'(instr[1:0]);
      default: b = 0;
    endcase
    res = (op == 3) ? ((a - b) & 255) : ((a + b) & 255);
    sb.push_back('{res, int'(instr[5:4])});
    rf[instr[5:4]] = res;
    @(negedge clk);
    ext_we = 1'b0;
    if (!hold) in_valid = 1'b0;
    chk("ready_in_read", {15'h0, in_ready}, 16'd0);
    if (ext_read) begin
      ext_we = 1'b1; ext_addr = ra[1:0]; ext_data = rdat[7:0];
    end
    @(negedge clk);
    ext_we = 1'b0;
    chk("alu_A", {8'h0, alu_A}, a[15:0]);
    chk("alu_B", {8'h0, alu_B}, b[15:0]);
    chk("alu_op", {15'h0, alu_op}, (op == 3) ? 16'd1 : 16'd0);
    chk("ready_in_exec", {15'h0, in_ready}, 16'd0);
  endtask

  task automatic simple(input logic [7:0] instr);
    issue(instr, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    for (int i = 0; i < 4; i++) rf[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {15'h0, in_ready}, 16'd0);
    chk("reset_alu_A", {8'h0, alu_A}, 16'd0);
    chk("reset_alu_B", {8'h0, alu_B}, 16'd0);
    chk("reset_alu_op", {15'h0, alu_op}, 16'd0);
    chk("reset_result", {8'h0, result}, 16'd0);
    chk("reset_result_rd", {14'h0, result_rd}, 16'd0);
    chk("reset_result_valid", {15'h0, result_valid}, 16'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {15'h0, in_ready}, 16'd1);
    @(negedge clk);

    ext_wr(0, 8'h05); ext_wr(1, 8'h03);
    simple(mk(0, 2, 0, 1));                 // ADD r2=r0+r1 -> 08
    ext_wr(0, 8'hF0); ext_wr(1, 8'h20);
    simple(mk(0, 0, 0, 1));                 // wrap, rd==rs -> 10
    simple(mk(1, 3, 2, 3));                 // ADDI r3=r2+3 -> 0B
    simple(mk(2, 1, 3, 0));                 // MOV r1=r3 -> 0B

    // in_valid held high across three back-to-back instructions
    issue(mk(0, 0, 0, 1), 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    issue(mk(0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    issue(mk(0, 2, 0, 3), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    simple(mk(3, 2, 1, 0));                 // SUB

    // ext write during READ is ignored; coincident with accept it is used
    issue(mk(2, 3, 0, 0), 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1, 8'hAA);
    simple(mk(2, 3, 1, 0));
    issue(mk(0, 2, 1, 1), 1'b0, 1'b0, 1'b1, 1, 8'h40, 1'b0, 0, 0);

    // reset during EXEC aborts the instruction and clears the file
    wait_ready();
    in_valid = 1'b1; in_instr = mk(0, 0, 1, 2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_no_valid", {15'h0, result_valid}, 16'd0);
    chk("abort_ready_in_reset", {15'h0, in_ready}, 16'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", {15'h0, in_ready}, 16'd1);
    for (int i = 0; i < 4; i++) rf[i] = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) simple(mk(2, i, i, 0));

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) ext_wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      issue(8'($urandom), 1'b0, 1'b0,
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
